// File: rtl/sd_dat_tx_wide.sv
// rtl/sd_dat_tx_wide.sv - SD DAT block transmitter on 1 or NLANES lanes with per-lane CRC16
module sd_dat_tx_wide #(
    parameter int NLANES = 4,
    parameter int BLW    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              wide,
    input  logic [BLW-1:0]    blklen,
    input  logic [7:0]        din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [NLANES-1:0] dat_o,
    output logic [NLANES-1:0] dat_oe,
    output logic              stall,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_CRC, S_END} state_t;

    localparam logic WIDE_OK = (NLANES == 4);

    state_t            state;
    logic              wide_r;
    logic [BLW-1:0]    blklen_r;
    logic [BLW-1:0]    acc_cnt;
    logic [BLW-1:0]    sent_cnt;
    logic [7:0]        hold_byte;
    logic              hold_full;
    logic [7:0]        shreg;
    logic [3:0]        phase;
    logic [4:0]        crc_cnt;
    logic [15:0]       crc [NLANES];

    logic [NLANES-1:0] act;
    logic [NLANES-1:0] start_act;
    logic [NLANES-1:0] lane_bits;
    logic [NLANES-1:0] crc_bits;
    logic              xfer;
    logic              byte_avail;
    logic              fetch;
    logic              finish;
    logic              take;
    logic [7:0]        next_byte;
    logic [7:0]        src;
    logic [3:0]        last_ph;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    // A byte arriving on the same cycle as a boundary is bypassed straight into
    // the shift register so a continuously valid stream never stalls.
    always_comb begin
        act        = wide_r ? {NLANES{1'b1}} : NLANES'(1);
        start_act  = (wide && WIDE_OK) ? {NLANES{1'b1}} : NLANES'(1);
        din_ready  = !hold_full && (state == S_START || state == S_DATA) && (acc_cnt < blklen_r);
        xfer       = din_valid && din_ready;
        byte_avail = hold_full || xfer;
        next_byte  = hold_full ? hold_byte : din;
        last_ph    = wide_r ? 4'd2 : 4'd8;
        fetch      = 1'b0;
        finish     = 1'b0;
        if (state == S_START) begin
            fetch  = (blklen_r != '0);
            finish = (blklen_r == '0);
        end else if (state == S_DATA && (stall || phase == last_ph)) begin
            fetch  = (sent_cnt != blklen_r);
            finish = (sent_cnt == blklen_r);
        end
        take = fetch && byte_avail;
        src  = take ? next_byte : shreg;
        for (int l = 0; l < NLANES; l++) begin
            lane_bits[l] = wide_r ? src[4+l] : ((l == 0) ? src[7] : 1'b1);
            crc_bits[l]  = act[l] ? crc[l][15] : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            wide_r    <= 1'b0;
            blklen_r  <= '0;
            acc_cnt   <= '0;
            sent_cnt  <= '0;
            hold_byte <= '0;
            hold_full <= 1'b0;
            shreg     <= '0;
            phase     <= '0;
            crc_cnt   <= '0;
            for (int l = 0; l < NLANES; l++) crc[l] <= '0;
            dat_o     <= '1;
            dat_oe    <= '0;
            stall     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (xfer) acc_cnt <= acc_cnt + 1'b1;
            if (take) begin
                hold_full <= 1'b0;
            end else if (xfer) begin
                hold_full <= 1'b1;
                hold_byte <= din;
            end
            case (state)
                S_IDLE: if (start) begin
                    state    <= S_START;
                    wide_r   <= wide && WIDE_OK;
                    blklen_r <= blklen;
                    acc_cnt  <= '0;
                    sent_cnt <= '0;
                    phase    <= '0;
                    for (int l = 0; l < NLANES; l++) crc[l] <= '0;
                    dat_o    <= ~start_act;
                    dat_oe   <= start_act;
                    busy     <= 1'b1;
                end
                S_START, S_DATA: begin
                    if (finish) begin
                        state   <= S_CRC;
                        dat_o   <= crc_bits;
                        crc_cnt <= 5'd1;
                        for (int l = 0; l < NLANES; l++) crc[l] <= crc[l] << 1;
                    end else if (fetch && !byte_avail) begin
                        // underrun: everything holds, dat_o keeps its last bit
                        state <= S_DATA;
                        stall <= 1'b1;
                    end else begin
                        state <= S_DATA;
                        stall <= 1'b0;
                        dat_o <= lane_bits;
                        shreg <= wide_r ? (src << 4) : (src << 1);
                        phase <= take ? 4'd1 : phase + 4'd1;
                        if (take) sent_cnt <= sent_cnt + 1'b1;
                        for (int l = 0; l < NLANES; l++)
                            if (act[l]) crc[l] <= crc_step(crc[l], lane_bits[l]);
                    end
                end
                S_CRC: begin
                    if (crc_cnt == 5'd16) begin
                        state <= S_END;
                        dat_o <= '1;
                    end else begin
                        dat_o   <= crc_bits;
                        crc_cnt <= crc_cnt + 5'd1;
                        for (int l = 0; l < NLANES; l++) crc[l] <= crc[l] << 1;
                    end
                end
                S_END: begin
                    state  <= S_IDLE;
                    dat_o  <= '1;
                    dat_oe <= '0;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_dat_tx_wide.sv
// tb/tb_sd_dat_tx_wide.sv - randomized self-checking bench for sd_dat_tx_wide
module tb_sd_dat_tx_wide;
    logic       clk = 1'b0;
    logic       reset, start, wide, din_valid;
    logic [9:0] blklen;
    logic [7:0] din;
    logic       din_ready, stall, busy, done;
    logic [3:0] dat_o, dat_oe;

    int checks = 0;
    int failures = 0;

    logic [7:0] tx[$];
    logic [3:0] cap[$];
    logic [3:0] exp_q[$];
    bit         lane_bits[4][$];
    int busy_cnt, stall_cnt, hs_cnt, done_cnt, frozen_err, oe_err;

    always #5 clk = ~clk;

    sd_dat_tx_wide #(.NLANES(4), .BLW(10)) dut (
        .clk(clk), .reset(reset), .start(start), .wide(wide), .blklen(blklen),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dat_o(dat_o), .dat_oe(dat_oe), .stall(stall), .busy(busy), .done(done)
    );

    // CRC as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1
    function automatic logic [15:0] crc_div(input int l);
        bit m[$];
        logic [16:0] g;
        logic [15:0] r;
        int n;
        g = 17'h11021;
        m = lane_bits[l];
        n = m.size();
        for (int k = 0; k < 16; k++) m.push_back(1'b0);
        for (int i = 0; i < n; i++)
            if (m[i]) for (int j = 0; j < 17; j++) m[i+j] = m[i+j] ^ g[16-j];
        for (int k = 0; k < 16; k++) r[15-k] = m[n+k];
        return r;
    endfunction

    task automatic fill_tx(input int n, input int val);
        tx.delete();
        for (int i = 0; i < n; i++) tx.push_back(val < 0 ? 8'($urandom) : 8'(val));
    endtask

    task automatic build_expected(input bit w, input int n);
        logic [3:0]  act, v;
        logic [15:0] c [4];
        act = w ? 4'hF : 4'h1;
        exp_q.delete();
        for (int l = 0; l < 4; l++) lane_bits[l].delete();
        exp_q.push_back(~act);
        for (int b = 0; b < n; b++) begin
            if (w) begin
                for (int h = 1; h >= 0; h--) begin
                    v = tx[b][4*h +: 4];
                    exp_q.push_back(v);
                    for (int l = 0; l < 4; l++) lane_bits[l].push_back(v[l]);
                end
            end else begin
                for (int i = 7; i >= 0; i--) begin
                    exp_q.push_back({3'b111, tx[b][i]});
                    lane_bits[0].push_back(tx[b][i]);
                end
            end
        end
        for (int l = 0; l < 4; l++) c[l] = crc_div(l);
        for (int k = 15; k >= 0; k--) begin
            v = 4'hF;
            for (int l = 0; l < 4; l++) if (act[l]) v[l] = c[l][k];
            exp_q.push_back(v);
        end
        exp_q.push_back(4'hF);
    endtask

    function automatic int stream_mismatches();
        int mm;
        mm = (cap.size() > exp_q.size()) ? cap.size() - exp_q.size() : exp_q.size() - cap.size();
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
            if (cap[i] !== exp_q[i]) mm++;
        return mm;
    endfunction

    task automatic apply_reset();
        reset = 1'b1; start = 1'b0; din_valid = 1'b0; wide = 1'b0; blklen = '0; din = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic run_block(input bit w, input int n, input int gap_pct, input int drop_len,
                             input int restart_at, input bit chain, input bit over);
        logic [3:0] act, prev;
        int idx, post, drop_left, limit;
        bit chained, drop_active;
        act = w ? 4'hF : 4'h1;
        cap.delete();
        busy_cnt = 0; stall_cnt = 0; hs_cnt = 0; done_cnt = 0; frozen_err = 0; oe_err = 0;
        idx = 0; post = 0; drop_left = drop_len; chained = 1'b0;
        limit = 400 + n * 40;
        wide = w; blklen = 10'(n); start = 1'b1; din_valid = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        wide = 1'($urandom); blklen = 10'($urandom);
        prev = dat_o;
        for (int cyc = 0; cyc < limit && post < 4; cyc++) begin
            if (done) done_cnt++;
            if (done_cnt > 0) post++;
            if (busy) begin
                busy_cnt++;
                if (dat_oe !== act) oe_err++;
                if (stall) begin
                    stall_cnt++;
                    if (dat_o !== prev) frozen_err++;
                end else begin
                    cap.push_back(dat_o);
                end
            end
            prev = dat_o;
            start = (cyc == restart_at);
            drop_active = (hs_cnt >= 2) && (drop_left > 0);
            if (drop_active) drop_left--;
            din_valid = (idx < n || over) && !drop_active && ($urandom_range(99) >= gap_pct);
            din = (idx < n) ? tx[idx] : 8'($urandom);
            if (din_valid && din_ready) begin
                hs_cnt++;
                idx++;
            end
            if (chain && done) begin
                start = 1'b1; wide = 1'b0; blklen = '0; chained = 1'b1;
            end
            @(posedge clk);
            #1;
            if (chained) begin
                start = 1'b0;
                break;
            end
        end
        din_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (dat_o !== 4'hF) begin failures++; $display("FAIL reset_dat_o got=%h exp=f", dat_o); end
        checks++; if (dat_oe !== 4'h0) begin failures++; $display("FAIL reset_dat_oe got=%h exp=0", dat_oe); end
        checks++; if (din_ready !== 1'b0) begin failures++; $display("FAIL reset_din_ready got=%b exp=0", din_ready); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    endtask

    task automatic test_ones_1bit();
        logic [15:0] r;
        int mm;
        apply_reset();
        fill_tx(512, 'hFF);
        build_expected(1'b0, 512);
        run_block(1'b0, 512, 0, 0, -1, 1'b0, 1'b0);
        mm = stream_mismatches();
        checks++; if (mm != 0) begin failures++; $display("FAIL ones1_stream mismatches=%0d got_len=%0d exp_len=%0d", mm, cap.size(), exp_q.size()); end
        for (int k = 0; k < 16; k++) r[15-k] = (4097 + k < cap.size()) ? cap[4097+k][0] : 1'bx;
        checks++; if (r !== 16'h7FA1) begin failures++; $display("FAIL ones1_crc got=%h exp=7fa1", r); end
        checks++; if (busy_cnt != 4114) begin failures++; $display("FAIL ones1_busy got=%0d exp=4114", busy_cnt); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL ones1_done got=%0d exp=1", done_cnt); end
        checks++; if (hs_cnt != 512) begin failures++; $display("FAIL ones1_handshakes got=%0d exp=512", hs_cnt); end
        checks++; if (oe_err != 0) begin failures++; $display("FAIL ones1_oe bad_cycles=%0d exp=0", oe_err); end
    endtask

    task automatic test_ones_4bit();
        logic [15:0] lc [4];
        int mm;
        apply_reset();
        fill_tx(512, 'hFF);
        build_expected(1'b1, 512);
        run_block(1'b1, 512, 0, 0, -1, 1'b0, 1'b0);
        mm = stream_mismatches();
        checks++; if (mm != 0) begin failures++; $display("FAIL ones4_stream mismatches=%0d got_len=%0d exp_len=%0d", mm, cap.size(), exp_q.size()); end
        for (int l = 0; l < 4; l++)
            for (int k = 0; k < 16; k++) lc[l][15-k] = (1025 + k < cap.size()) ? cap[1025+k][l] : 1'bx;
        checks++;
        if (lc[0] !== lc[1] || lc[0] !== lc[2] || lc[0] !== lc[3]) begin
            failures++; $display("FAIL ones4_lane_crc got=%h/%h/%h/%h exp=all_equal", lc[0], lc[1], lc[2], lc[3]);
        end
        checks++; if (busy_cnt != 1042) begin failures++; $display("FAIL ones4_busy got=%0d exp=1042", busy_cnt); end
        checks++; if (oe_err != 0) begin failures++; $display("FAIL ones4_oe bad_cycles=%0d exp=0", oe_err); end
    endtask

    task automatic test_two_bytes();
        int mm;
        apply_reset();
        tx.delete(); tx.push_back(8'hA5); tx.push_back(8'h3C);
        build_expected(1'b0, 2);
        run_block(1'b0, 2, 0, 0, -1, 1'b0, 1'b1);
        mm = stream_mismatches();
        checks++; if (mm != 0) begin failures++; $display("FAIL two_stream mismatches=%0d got_len=%0d exp_len=%0d", mm, cap.size(), exp_q.size()); end
        checks++; if (hs_cnt != 2) begin failures++; $display("FAIL two_handshakes got=%0d exp=2", hs_cnt); end
        checks++; if (busy_cnt != 34) begin failures++; $display("FAIL two_busy got=%0d exp=34", busy_cnt); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL two_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_underrun();
        int mm;
        apply_reset();
        fill_tx(4, -1);
        build_expected(1'b1, 4);
        run_block(1'b1, 4, 0, $urandom_range(4, 10), -1, 1'b0, 1'b0);
        mm = stream_mismatches();
        checks++; if (stall_cnt == 0) begin failures++; $display("FAIL underrun_stall got=0 exp=nonzero"); end
        checks++; if (frozen_err != 0) begin failures++; $display("FAIL underrun_frozen moved=%0d exp=0", frozen_err); end
        checks++; if (mm != 0) begin failures++; $display("FAIL underrun_stream mismatches=%0d got_len=%0d exp_len=%0d", mm, cap.size(), exp_q.size()); end
        checks++; if (busy_cnt != 26 + stall_cnt) begin failures++; $display("FAIL underrun_busy got=%0d exp=%0d", busy_cnt, 26 + stall_cnt); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL underrun_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int mm;
        apply_reset();
        wide = 1'b0; blklen = 10'd512; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 101; i++) begin
            din_valid = 1'b1; din = 8'($urandom);
            @(posedge clk);
            #1;
        end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
        reset = 1'b1; din_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        checks++; if (dat_o !== 4'hF) begin failures++; $display("FAIL midrst_dat_o got=%h exp=f", dat_o); end
        checks++; if (dat_oe !== 4'h0) begin failures++; $display("FAIL midrst_dat_oe got=%h exp=0", dat_oe); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done || busy) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++; if (seen) begin failures++; $display("FAIL midrst_quiet got=activity exp=idle"); end
        fill_tx(8, -1);
        build_expected(1'b0, 8);
        run_block(1'b0, 8, 30, 0, -1, 1'b0, 1'b0);
        mm = stream_mismatches();
        checks++; if (mm != 0) begin failures++; $display("FAIL midrst_clean_stream mismatches=%0d got_len=%0d exp_len=%0d", mm, cap.size(), exp_q.size()); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL midrst_clean_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_blklen_zero();
        int mm;
        apply_reset();
        tx.delete();
        build_expected(1'b0, 0);
        run_block(1'b0, 0, 0, 0, 8, 1'b0, 1'b0);
        mm = stream_mismatches();
        checks++; if (mm != 0) begin failures++; $display("FAIL zero_stream mismatches=%0d got_len=%0d exp_len=%0d", mm, cap.size(), exp_q.size()); end
        checks++; if (busy_cnt != 18) begin failures++; $display("FAIL zero_busy got=%0d exp=18", busy_cnt); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL zero_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_back_to_back();
        bit seen;
        int n, mm;
        apply_reset();
        n = $urandom_range(1, 6);
        fill_tx(n, -1);
        build_expected(1'b1, n);
        run_block(1'b1, n, 20, 0, -1, 1'b1, 1'b0);
        mm = stream_mismatches();
        checks++; if (mm != 0) begin failures++; $display("FAIL b2b_stream mismatches=%0d got_len=%0d exp_len=%0d", mm, cap.size(), exp_q.size()); end
        checks++; if (busy !== 1'b1 || dat_o !== 4'hE || dat_oe !== 4'h1) begin
            failures++; $display("FAIL b2b_restart got busy=%b dat_o=%h dat_oe=%h exp busy=1 dat_o=e dat_oe=1", busy, dat_o, dat_oe);
        end
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk);
            #1 if (done) seen = 1'b1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL b2b_second_done got=none exp=pulse"); end
    endtask

    task automatic test_random();
        bit w;
        int n, mm, base;
        for (int it = 0; it < 6; it++) begin
            w = 1'($urandom);
            n = $urandom_range(0, 24);
            fill_tx(n, -1);
            build_expected(w, n);
            run_block(w, n, $urandom_range(0, 60), 0, -1, 1'b0, 1'b0);
            mm = stream_mismatches();
            base = 1 + (w ? 2 : 8) * n + 17;
            checks++; if (mm != 0) begin failures++; $display("FAIL rand%0d_stream w=%0d n=%0d mismatches=%0d", it, w, n, mm); end
            checks++; if (busy_cnt != base + stall_cnt) begin failures++; $display("FAIL rand%0d_busy got=%0d exp=%0d", it, busy_cnt, base + stall_cnt); end
            checks++; if (done_cnt != 1) begin failures++; $display("FAIL rand%0d_done got=%0d exp=1", it, done_cnt); end
            checks++; if (hs_cnt != n) begin failures++; $display("FAIL rand%0d_handshakes got=%0d exp=%0d", it, hs_cnt, n); end
            checks++; if (frozen_err != 0 || oe_err != 0) begin failures++; $display("FAIL rand%0d_hold_oe frozen=%0d oe=%0d exp=0", it, frozen_err, oe_err); end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; wide = 1'b0; blklen = '0; din = '0; din_valid = 1'b0;
        test_reset();
        test_ones_1bit();
        test_ones_4bit();
        test_two_bytes();
        test_underrun();
        test_reset_mid();
        test_blklen_zero();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sd_dat_tx_wide.md
Name: sd_dat_tx_wide

Overview:
- Parametrised successor of the single-lane DAT transmitter.
- Serialises one complete SD data block onto 1 or NLANES DAT lines: start bit, payload, per-lane CRC16, end bit.
- Payload arrives over a valid/ready byte stream from the FIFO/RAM muxes.
- Computes CRC16 internally per lane, so the caller supplies no CRC bytes. Sits between the data-source mux and the DAT pad drivers, beside the SD clock generator.

Parameters:
- NLANES, 4, physical DAT lanes (legal values 1 or 4).
- BLW, 10, width of the blklen port; max block = 2^BLW-1 bytes.

Ports:
- clk  in  1  clock; one DAT bit-time per clk cycle.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to send a block; ignored while busy.
- wide  in  1  1 = 4-bit mode (only honoured when NLANES=4); sampled with start.
- blklen  in  BLW  payload bytes; sampled with start.
- din  in  8  payload byte.
- din_valid  in  1  din holds a valid byte.
- din_ready  out  1  block accepts din this cycle.
- dat_o  out  NLANES  serial DAT outputs; bit 0 = DAT0.
- dat_oe  out  NLANES  per-lane output enable.
- stall  out  1  payload underrun; SD clock generator gates the card clock while high.
- busy  out  1  high from the cycle after start is accepted through the END cycle.
- done  out  1  one-cycle pulse after the end bit.

Behaviour:
- All registers update on posedge clk. Reset is synchronous and active-high.
- Reset values: dat_o all 1, dat_oe 0, din_ready 0, stall 0, busy 0, done 0, FSM IDLE, byte buffer empty, CRCs 0.
- Active lanes: lane 0 only if wide=0 or NLANES=1; otherwise lanes 0..3.
  - Inactive lanes: dat_o=1, dat_oe=0 at all times.
- FSM: IDLE -> START -> DATA -> CRC -> END -> IDLE.
- IDLE: on start=1, latch wide and blklen, clear CRCs and the bit counter. Next cycle enter START.
  - Latency: start sampled at cycle k -> start bit on dat_o at cycle k+1.
- START: 1 cycle; active lanes drive 0, dat_oe=1 on active lanes, busy=1.
  - Next state: DATA if blklen>0, else CRC.
- Byte buffer: one holding register plus the shift register.
  - din_ready=1 when the holding register is empty, the state is START or DATA, and fewer than blklen bytes have been accepted.
  - A transfer occurs on din_valid & din_ready.
- DATA:
  - 1-bit mode: 8 cycles per byte, MSB first, on lane 0.
  - 4-bit mode: 2 cycles per byte, high nibble first; nibble bit3 -> DAT3 ... bit0 -> DAT0.
  - At each byte boundary the next byte moves from the holding register into the shift register.
  - Underrun: holding register empty at a boundary while bytes remain. Set stall=1, hold dat_o at the last bit value, and freeze counters and CRC. Resume on the cycle after a byte arrives, with stall=0 in that cycle.
  - After the last bit of byte blklen-1, enter CRC.
- CRC16 per active lane:
  - Polynomial x^16+x^12+x^5+1 (0x1021), init 0x0000.
  - Updated with each payload bit driven on that lane. Start bit excluded.
- CRC: 16 cycles; each active lane shifts out its own CRC MSB first. Then END.
- END: 1 cycle; active lanes drive 1 with dat_oe=1. Next cycle:
  - IDLE, dat_oe=0, busy=0, done=1 for exactly that cycle.
- Total busy cycles:
  - 1-bit: 1+8*blklen+16+1.
  - 4-bit: 1+2*blklen+16+1 (stalls excluded).
- start asserted while busy: ignored, with no effect on the block in flight. start in the same cycle as done: accepted.
- Bytes offered beyond blklen: not accepted; din_ready stays 0.
- reset mid-block: next cycle outputs at reset values. Holding byte discarded, no done pulse, no partial CRC emitted.
- wide=1 with NLANES=1: treated as wide=0.

Test Plan:
- 1-bit, blklen=512, all bytes 0xFF, din_valid held high:
  - dat_o[0] = 0, then 4096 ones, then CRC 0x7FA1 MSB first, then 1.
  - busy for 4114 cycles; done pulses once.
- 4-bit, blklen=512, all 0xFF:
  - start bit on DAT0..3.
  - 1024 payload cycles of 0xF; all four lane CRCs identical and equal to the golden model.
  - busy 1042 cycles.
- 1-bit, blklen=2, bytes 0xA5,0x3C:
  - dat_o[0] = 0, 10100101 00111100, golden-model CRC, 1.
  - Exactly two din_ready&din_valid handshakes.
- Underrun: 4-bit, blklen=4, din_valid dropped 5 cycles after the 2nd byte:
  - stall=1 with dat_o frozen until valid returns.
  - Lane CRCs match the no-stall run; total cycles = 26 + stall cycles.
- Reset at payload cycle 100 of a 512-byte block:
  - next cycle dat_o=all 1, dat_oe=0, busy=0, no done.
  - A subsequent start sends a clean block with correct CRC.
- blklen=0, 1-bit:
  - 0, sixteen 0s (CRC 0x0000), 1; 18 busy cycles.
  - start pulsed again during CRC is ignored.
